display_scheduler: RTL



---
 rtl/display_sched_pkg.sv | 28 ++
 rtl/display_scheduler_if.sv | 28 ++
 rtl/display_scheduler_tick_prescaler.sv | 29 ++
 rtl/display_scheduler.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/display_sched_pkg.sv
// Shared types and constants for the display scheduler: state encoding,
// display mode constants and message-code helpers.
package display_sched_pkg;

    localparam int unsigned MODE_W  = 4;
    localparam int unsigned INDEX_W = 2;
    localparam int unsigned CODE_W  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CURSOR  = 2'd1,
        MESSAGE = 2'd2
    } state_t;

    localparam logic [MODE_W-1:0] MODE_CURSOR = 4'b0000;
    localparam logic [MODE_W-1:0] MODE_BLANK  = 4'b1111;
    localparam logic [CODE_W-1:0] MSG_MIN     = 3'd1;
    localparam logic [CODE_W-1:0] MSG_MAX     = 3'd4;

    function automatic logic msg_code_valid(input logic [CODE_W-1:0] code);
        return (code >= MSG_MIN) && (code <= MSG_MAX);
    endfunction

    function automatic logic [MODE_W-1:0] msg_mode(input logic [CODE_W-1:0] code);
        return {1'b0, code};
    endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// Requester/display bus of the display scheduler; master is the game/control
// side, slave is the scheduler itself.
interface display_scheduler_if;
    import display_sched_pkg::*;

    logic               CursorValid;
    logic [INDEX_W-1:0] CursorIndex;
    logic               CursorValue;
    logic               MsgReq;
    logic [CODE_W-1:0]  MsgCode;
    logic               MsgAck;
    logic               MsgDone;
    logic               Busy;
    logic [MODE_W-1:0]  DisplayMode;
    logic [INDEX_W-1:0] DisplayIndex;
    logic               DisplayValue;

    modport master (
        output CursorValid, CursorIndex, CursorValue, MsgReq, MsgCode,
        input  MsgAck, MsgDone, Busy, DisplayMode, DisplayIndex, DisplayValue
    );

    modport slave (
        input  CursorValid, CursorIndex, CursorValue, MsgReq, MsgCode,
        output MsgAck, MsgDone, Busy, DisplayMode, DisplayIndex, DisplayValue
    );

endinterface

// File: rtl/display_scheduler_tick_prescaler.sv
// Dwell-tick prescaler: counts 0..TickDiv-1 while enabled and flags a
// one-cycle tick enable on the last count.
module tick_prescaler #(
    parameter int unsigned TickDiv     = 50000000,
    parameter int unsigned TickDivSize = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick_c
);

    localparam logic [TickDivSize-1:0] LAST = TickDivSize'(TickDiv - 1);

    logic [TickDivSize-1:0] count;

    assign tick_c = enable && (count == LAST);

    // Wrap on the tick so back-to-back dwell periods stay exactly TickDiv long.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick_c ? '0 : count + TickDivSize'(1);
        end
    end

endmodule

// File: rtl/display_scheduler.sv
// Display scheduler: arbitrates the 4-digit display between a background
// cursor and timed foreground messages. Optional macro DISPLAY_SCHED_QUEUE_EN
// adds a one-entry pending-message slot.
module display_scheduler
    import display_sched_pkg::*;
#(
    parameter int unsigned TickDiv     = 50000000,
    parameter int unsigned TickDivSize = 26,
    parameter int unsigned DwellTicks  = 4,
    parameter int unsigned DwellSize   = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    display_scheduler_if.slave bus
);

    localparam logic [DwellSize-1:0] DWELL_INIT =
        (DwellTicks == 0) ? DwellSize'(1) : DwellSize'(DwellTicks);

    state_t               state, state_n;
    logic [MODE_W-1:0]    mode_n;
    logic                 ack_n, done_n, busy_n;
    logic [DwellSize-1:0] dwell, dwell_n;
    logic                 load_c, presc_clear_c, tick_c, req_ok_c;

`ifdef DISPLAY_SCHED_QUEUE_EN
    logic              slot_full, slot_full_n;
    logic [CODE_W-1:0] slot_code, slot_code_n;
`endif

    tick_prescaler #(
        .TickDiv     (TickDiv),
        .TickDivSize (TickDivSize)
    ) u_prescaler (
        .clk    (Clk),
        .reset  (Reset),
        .clear  (presc_clear_c),
        .enable (state == MESSAGE),
        .tick_c (tick_c)
    );

    assign req_ok_c = bus.MsgReq && msg_code_valid(bus.MsgCode);

    // Next state and next registered outputs.
    always_comb begin
        state_n = state;
        mode_n  = bus.DisplayMode;
        ack_n   = 1'b0;
        done_n  = 1'b0;
        dwell_n = dwell;
        load_c  = 1'b0;
`ifdef DISPLAY_SCHED_QUEUE_EN
        slot_full_n = slot_full;
        slot_code_n = slot_code;
`endif
        case (state)
            IDLE, CURSOR: begin
                if (req_ok_c) begin
                    state_n = MESSAGE;
                    mode_n  = msg_mode(bus.MsgCode);
                    ack_n   = 1'b1;
                    dwell_n = DWELL_INIT;
                    load_c  = 1'b1;
                end else if (bus.CursorValid) begin
                    state_n = CURSOR;
                    mode_n  = MODE_CURSOR;
                end else begin
                    state_n = IDLE;
                    mode_n  = MODE_BLANK;
                end
            end
            MESSAGE: begin
                if (tick_c) begin
                    if (dwell > DwellSize'(1)) begin
                        dwell_n = dwell - DwellSize'(1);
                    end else begin
                        done_n  = 1'b1;
                        dwell_n = '0;
`ifdef DISPLAY_SCHED_QUEUE_EN
                        if (slot_full) begin
                            mode_n      = msg_mode(slot_code);
                            dwell_n     = DWELL_INIT;
                            load_c      = 1'b1;
                            slot_full_n = 1'b0;
                        end else if (req_ok_c) begin
                            mode_n  = msg_mode(bus.MsgCode);
                            ack_n   = 1'b1;
                            dwell_n = DWELL_INIT;
                            load_c  = 1'b1;
                        end else begin
                            state_n = bus.CursorValid ? CURSOR : IDLE;
                            mode_n  = bus.CursorValid ? MODE_CURSOR : MODE_BLANK;
                        end
`else
                        state_n = bus.CursorValid ? CURSOR : IDLE;
                        mode_n  = bus.CursorValid ? MODE_CURSOR : MODE_BLANK;
`endif
                    end
                end
`ifdef DISPLAY_SCHED_QUEUE_EN
                // Park a new request in the slot unless it was taken directly above.
                if (req_ok_c && !slot_full && !ack_n) begin
                    ack_n       = 1'b1;
                    slot_full_n = 1'b1;
                    slot_code_n = bus.MsgCode;
                end
`endif
            end
            default: begin
                state_n = IDLE;
                mode_n  = MODE_BLANK;
            end
        endcase
        busy_n        = (state_n == MESSAGE);
        presc_clear_c = load_c || (state != MESSAGE);
    end

    // DisplayIndex/DisplayValue double as the cursor shadow, captured every cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state            <= IDLE;
            dwell            <= '0;
            bus.DisplayMode  <= MODE_BLANK;
            bus.DisplayIndex <= '0;
            bus.DisplayValue <= 1'b0;
            bus.MsgAck       <= 1'b0;
            bus.MsgDone      <= 1'b0;
            bus.Busy         <= 1'b0;
        end else begin
            state            <= state_n;
            dwell            <= dwell_n;
            bus.DisplayMode  <= mode_n;
            bus.DisplayIndex <= bus.CursorIndex;
            bus.DisplayValue <= bus.CursorValue;
            bus.MsgAck       <= ack_n;
            bus.MsgDone      <= done_n;
            bus.Busy         <= busy_n;
        end
    end

`ifdef DISPLAY_SCHED_QUEUE_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            slot_full <= 1'b0;
            slot_code <= '0;
        end else begin
            slot_full <= slot_full_n;
            slot_code <= slot_code_n;
        end
    end
`endif

endmodule
